// File: rtl/usb_link_pkg.sv
// Shared types and defaults for the USB half-duplex line arbiter.
package usb_link_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_RX        = 3'd1,
      ST_TX        = 3'd2,
      ST_GAP       = 3'd3,
      ST_WAIT_RESP = 3'd4
   } link_state_t;

   localparam int unsigned USB_IPD_CYCLES        = 16;
   localparam int unsigned USB_RX_TIMEOUT_CYCLES = 72;

   // Larger of two values; used to size the shared gap/timeout counter.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/link_timer.sv
// Up-counter with synchronous clear/enable and a terminal-count comparator.
module link_timer #(
   parameter int unsigned CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] match_val,
   output logic             hit
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear wins over enable.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = count_q + 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Terminal match against the current count.
   always_comb begin
      hit = (count_q == match_val);
   end

endmodule

// File: rtl/usb_link_arbiter.sv
// Half-duplex D+/D- ownership controller: grants the line to TX, keeps RX
// enabled otherwise, enforces the inter-packet gap and a response timeout.
module usb_link_arbiter
   import usb_link_pkg::*;
#(
   parameter int unsigned IPD_CYCLES        = USB_IPD_CYCLES,
   parameter int unsigned RX_TIMEOUT_CYCLES = USB_RX_TIMEOUT_CYCLES,
   parameter int unsigned CNT_W             = $clog2(max_u(IPD_CYCLES, RX_TIMEOUT_CYCLES) + 1)
) (
   input  logic       clk,
   input  logic       RST,
   input  logic       tx_req,
   input  logic       tx_expect_resp,
   input  logic       tx_done,
   input  logic       rx_line_active,
   input  logic       rx_frame_complete,
   input  logic       rx_error_flag,
   output logic       tx_grant,
   output logic       drive_en,
   output logic       rx_enable,
   output logic       timeout,
   output logic       busy,
   output logic [2:0] link_state,
   output logic [7:0] rx_err_count
);

   localparam logic [CNT_W-1:0] IPD_LAST = CNT_W'(IPD_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(RX_TIMEOUT_CYCLES - 1);

   link_state_t state_q, state_d;
   logic        exp_q, exp_d;
   logic [7:0]  err_q, err_d;

   logic             tmr_clr;
   logic             tmr_en;
   logic             tmr_hit;
   logic [CNT_W-1:0] tmr_match;

   // Timer runs only in GAP/WAIT_RESP and is held at zero elsewhere, so every
   // entry into either state starts from a cleared count.
   always_comb begin
      tmr_en    = (state_q == ST_GAP) || (state_q == ST_WAIT_RESP);
      tmr_clr   = !tmr_en;
      tmr_match = (state_q == ST_WAIT_RESP) ? TO_LAST : IPD_LAST;
   end

   link_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk       (clk),
      .rst       (RST),
      .clr       (tmr_clr),
      .en        (tmr_en),
      .match_val (tmr_match),
      .hit       (tmr_hit)
   );

   // State, latched expect-response bit and error counter registers.
   always_ff @(posedge clk) begin
      if (RST) begin
         state_q <= ST_IDLE;
         exp_q   <= 1'b0;
         err_q   <= '0;
      end else begin
         state_q <= state_d;
         exp_q   <= exp_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; RX activity always preempts TX request and timeout.
   always_comb begin
      state_d = state_q;
      exp_d   = exp_q;
      err_d   = err_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_line_active) begin
               state_d = ST_RX;
            end else if (tx_req) begin
               state_d = ST_TX;
               exp_d   = tx_expect_resp;
            end
         end
         ST_RX: begin
            if (rx_error_flag) begin
               state_d = ST_GAP;
               if (err_q != '1) begin
                  err_d = err_q + 8'd1;
               end
            end else if (rx_frame_complete) begin
               state_d = ST_GAP;
            end
         end
         ST_TX: begin
            if (tx_done) begin
               state_d = exp_q ? ST_WAIT_RESP : ST_GAP;
            end
         end
         ST_GAP, ST_WAIT_RESP: begin
            if (rx_line_active) begin
               state_d = ST_RX;
            end else if (tmr_hit) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Moore outputs; timeout also depends on count and is suppressed when RX
   // activity takes the terminal cycle.
   always_comb begin
      tx_grant     = (state_q == ST_TX);
      drive_en     = (state_q == ST_TX);
      rx_enable    = (state_q != ST_TX);
      busy         = (state_q != ST_IDLE);
      timeout      = (state_q == ST_WAIT_RESP) && tmr_hit && !rx_line_active;
      link_state   = state_q;
      rx_err_count = err_q;
   end

endmodule

// File: tb/tb_usb_link_arbiter.sv
// Directed self-checking bench for usb_link_arbiter with default parameters.
module tb_usb_link_arbiter;

   logic       clk = 1'b0;
   logic       RST;
   logic       tx_req, tx_expect_resp, tx_done;
   logic       rx_line_active, rx_frame_complete, rx_error_flag;
   logic       tx_grant, drive_en, rx_enable, timeout, busy;
   logic [2:0] link_state;
   logic [7:0] rx_err_count;

   int n_err    = 0;
   int n_checks = 0;
   int to_cnt   = 0;

   usb_link_arbiter #(
      .IPD_CYCLES        (16),
      .RX_TIMEOUT_CYCLES (72)
   ) dut (
      .clk               (clk),
      .RST               (RST),
      .tx_req            (tx_req),
      .tx_expect_resp    (tx_expect_resp),
      .tx_done           (tx_done),
      .rx_line_active    (rx_line_active),
      .rx_frame_complete (rx_frame_complete),
      .rx_error_flag     (rx_error_flag),
      .tx_grant          (tx_grant),
      .drive_en          (drive_en),
      .rx_enable         (rx_enable),
      .timeout           (timeout),
      .busy              (busy),
      .link_state        (link_state),
      .rx_err_count      (rx_err_count)
   );

   always #5 clk = ~clk;

   // Count timeout pulses, sampled mid-cycle.
   always @(negedge clk) begin
      if (timeout === 1'b1) to_cnt++;
   end

   // Driver and receiver must never be enabled together.
   always @(negedge clk) begin
      if (RST === 1'b0) begin
         n_checks++;
         assert (!(drive_en === 1'b1 && rx_enable === 1'b1)) else begin
            n_err++;
            $error("FAIL drv_rx_excl observed=%0b%0b expected=not 11", drive_en, rx_enable);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_err++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   initial begin
      int g;
      int n;
      int to_base;

      RST = 1'b1;
      tx_req = 0; tx_expect_resp = 0; tx_done = 0;
      rx_line_active = 0; rx_frame_complete = 0; rx_error_flag = 0;
      step(); step();
      chk("rst_state", link_state, 0);
      chk("rst_grant", tx_grant, 0);
      chk("rst_drive", drive_en, 0);
      chk("rst_rxen", rx_enable, 1);
      chk("rst_timeout", timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_errcnt", rx_err_count, 0);
      RST = 1'b0;
      step();

      // Stray tx_done / rx_frame_complete in IDLE are ignored.
      tx_done = 1; rx_frame_complete = 1;
      step();
      tx_done = 0; rx_frame_complete = 0;
      chk("stray_idle", link_state, 0);

      // TX without response: 20 grant cycles, 16 gap cycles, then IDLE.
      to_base = to_cnt;
      tx_req = 1; tx_expect_resp = 0;
      step();
      tx_req = 0;
      chk("tx1_grant", tx_grant, 1);
      chk("tx1_drive", drive_en, 1);
      chk("tx1_rxen", rx_enable, 0);
      chk("tx1_state", link_state, 2);
      g = 1;
      for (int i = 0; i < 19; i++) begin
         step();
         if (tx_grant === 1'b1) g++;
      end
      tx_done = 1;
      step();
      tx_done = 0;
      chk("tx1_grant_len", g, 20);
      chk("tx1_gap_state", link_state, 3);
      chk("tx1_gap_drive", drive_en, 0);
      chk("tx1_gap_rxen", rx_enable, 1);
      g = 1;
      for (int i = 0; i < 15; i++) begin
         step();
         if (link_state === 3'd3) g++;
      end
      chk("tx1_gap_len", g, 16);
      step();
      chk("tx1_idle", link_state, 0);
      chk("tx1_busy", busy, 0);
      chk("tx1_no_timeout", to_cnt, to_base);

      // TX expecting a reply that never arrives: timeout 72 cycles after tx_done.
      tx_req = 1; tx_expect_resp = 1;
      step();
      tx_req = 0; tx_expect_resp = 0;
      tx_done = 1;
      step();
      tx_done = 0;
      chk("to_wait_state", link_state, 4);
      n = 1;
      while (timeout !== 1'b1 && n < 200) begin
         step();
         n++;
      end
      chk("to_latency", n, 72);
      chk("to_busy_during", busy, 1);
      step();
      chk("to_after_busy", busy, 0);
      chk("to_after_state", link_state, 0);
      chk("to_after_pulse", timeout, 0);
      chk("to_pulse_count", to_cnt, to_base + 1);

      // TX with reply 30 cycles after tx_done.
      to_base = to_cnt;
      tx_req = 1; tx_expect_resp = 1;
      step();
      tx_req = 0; tx_expect_resp = 0;
      tx_done = 1;
      step();
      tx_done = 0;
      repeat (29) step();
      rx_line_active = 1;
      step();
      chk("rep_rx_state", link_state, 1);
      repeat (3) step();
      rx_line_active = 0; rx_frame_complete = 1;
      step();
      rx_frame_complete = 0;
      chk("rep_gap_state", link_state, 3);
      repeat (15) step();
      chk("rep_gap_end", link_state, 3);
      step();
      chk("rep_idle", link_state, 0);
      chk("rep_no_timeout", to_cnt, to_base);

      // tx_req and rx_line_active together: RX wins; TX granted only after GAP.
      tx_req = 1; rx_line_active = 1;
      step();
      chk("sim_rx_state", link_state, 1);
      chk("sim_rx_grant", tx_grant, 0);
      rx_line_active = 0; rx_frame_complete = 1;
      step();
      rx_frame_complete = 0;
      g = 0;
      for (int i = 0; i < 16; i++) begin
         if (tx_grant === 1'b1) g++;
         step();
      end
      chk("sim_gap_nogrant", g, 0);
      chk("sim_idle", link_state, 0);
      step();
      chk("sim_grant", tx_grant, 1);
      tx_req = 0; tx_done = 1;
      step();
      tx_done = 0;
      repeat (16) step();
      chk("sim_back_idle", link_state, 0);

      // RX activity on the terminal WAIT_RESP cycle: no timeout, go to RX.
      to_base = to_cnt;
      tx_req = 1; tx_expect_resp = 1;
      step();
      tx_req = 0; tx_expect_resp = 0;
      tx_done = 1;
      step();
      tx_done = 0;
      repeat (71) step();
      chk("term_state", link_state, 4);
      rx_line_active = 1;
      #1;
      chk("term_timeout_masked", timeout, 0);
      step();
      chk("term_rx_state", link_state, 1);
      chk("term_no_pulse", to_cnt, to_base);
      rx_line_active = 0;

      // Error and complete together count once.
      rx_error_flag = 1; rx_frame_complete = 1;
      step();
      rx_error_flag = 0; rx_frame_complete = 0;
      chk("err_both_state", link_state, 3);
      chk("err_both_count", rx_err_count, 1);

      // 299 further error frames: count saturates at 255.
      for (int i = 2; i <= 300; i++) begin
         rx_line_active = 1;
         step();
         rx_line_active = 0; rx_error_flag = 1;
         step();
         rx_error_flag = 0;
         if (i == 3)   chk("err_cnt_3", rx_err_count, 3);
         if (i == 254) chk("err_cnt_254", rx_err_count, 254);
         if (i == 255) chk("err_cnt_255", rx_err_count, 255);
      end
      chk("err_cnt_sat", rx_err_count, 255);
      repeat (16) step();
      chk("err_idle", link_state, 0);

      // Reset 5 cycles into TX.
      tx_req = 1;
      step();
      tx_req = 0;
      repeat (4) step();
      chk("rst_tx_drive_pre", drive_en, 1);
      RST = 1;
      step();
      chk("rst_tx_drive", drive_en, 0);
      chk("rst_tx_rxen", rx_enable, 1);
      chk("rst_tx_state", link_state, 0);
      chk("rst_tx_errcnt", rx_err_count, 0);
      RST = 0;

      // Fresh TX after reset behaves normally with a full gap.
      tx_req = 1;
      step();
      tx_req = 0; tx_done = 1;
      step();
      tx_done = 0;
      repeat (15) step();
      chk("post_rst_gap", link_state, 3);
      step();
      chk("post_rst_idle", link_state, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/usb_link_arbiter.md
# usb_link_arbiter

Half-duplex line-ownership controller for the USB transceiver. It shares the single D+/D− pair between the transmit path and the receive path. It grants the line to the protocol layer for transmission, and keeps the receive path enabled whenever the line is not being driven. It enforces the inter-packet gap after every packet and times out when an expected response never arrives. The receive FSM feeds it `rx_line_active`, `rx_frame_complete` and `rx_error_flag`; the TX path and protocol layer use the grant handshake.

## Interface
Parameters:
- `IPD_CYCLES`, default 16: minimum idle gap after any packet, in clk cycles. Must be ≥ 1.
- `RX_TIMEOUT_CYCLES`, default 72: response wait window after a TX that expects a reply. Must be ≥ 1.
- `CNT_W`, default `$clog2(max(IPD_CYCLES,RX_TIMEOUT_CYCLES)+1)`: gap/timeout counter width.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `RST`  in  1  synchronous active-high reset
- `tx_req`  in  1  protocol layer requests the line; held until `tx_grant`
- `tx_expect_resp`  in  1  the granted packet expects a reply; sampled with the accepted request
- `tx_done`  in  1  one-cycle pulse from the TX path at the end of EOP
- `rx_line_active`  in  1  receive activity (RXActive/SYNC seen)
- `rx_frame_complete`  in  1  pulse: received frame terminated normally
- `rx_error_flag`  in  1  receive FSM in error/abort
- `tx_grant`  out  1  level; the line is owned by TX
- `drive_en`  out  1  line-driver output enable
- `rx_enable`  out  1  receive path enabled
- `timeout`  out  1  one-cycle pulse: response window expired
- `busy`  out  1  state ≠ IDLE
- `link_state`  out  3  current state encoding, for debug
- `rx_err_count`  out  8  saturating count of receive errors

## Operation
- States:
  - **IDLE**: `rx_enable`=1.
    - `rx_line_active` → RX. It has priority over `tx_req`.
    - Else `tx_req` → TX, latching `tx_expect_resp`.
  - **RX**: `rx_enable`=1.
    - `rx_error_flag` → GAP, and `rx_err_count` increments, saturating at 255.
    - Else `rx_frame_complete` → GAP.
    - If both assert in the same cycle, error handling applies.
  - **TX**: `tx_grant`=1, `drive_en`=1, `rx_enable`=0.
    - `tx_done` → WAIT_RESP if the latched expect bit is set, else GAP.
  - **GAP**: `rx_enable`=1. The counter is cleared on entry.
    - `rx_line_active` → RX, because the remote may start early.
    - Else at count == `IPD_CYCLES`−1 → IDLE.
  - **WAIT_RESP**: `rx_enable`=1. The counter is cleared on entry.
    - `rx_line_active` → RX. It has priority over timeout in the same cycle.
    - Else at count == `RX_TIMEOUT_CYCLES`−1: `timeout`=1 for that cycle, → IDLE.
- `tx_req` is never granted from GAP or WAIT_RESP; it waits for IDLE.
- An illegal `link_state` encoding → IDLE.
- Outputs are Moore-decoded from state, except `timeout`, which is decoded from state plus count.
- Reset values: state IDLE, counter 0, `tx_grant` 0, `drive_en` 0, `rx_enable` 1, `timeout` 0, `busy` 0, `rx_err_count` 0.

## Timing
- Grant latency: `tx_req`=1 and `rx_line_active`=0 in IDLE at edge k → `tx_grant`/`drive_en` high from cycle k+1.
- `tx_done` at edge k → `drive_en` low from k+1.
- GAP lasts exactly `IPD_CYCLES` cycles with no interruption.
- Timeout pulse occurs `RX_TIMEOUT_CYCLES` cycles after WAIT_RESP entry. IDLE follows the next cycle.
- `rx_enable` falls in the same cycle `drive_en` rises, and rises in the same cycle `drive_en` falls. The driver and receiver are never both enabled.
- Reset mid-TX: at the first edge with `RST`=1, `drive_en` goes low and the state goes to IDLE. An in-progress count is discarded.
- `tx_done` outside TX and `rx_frame_complete` outside RX are ignored.

## Structure
- `usb_link_pkg` holds:
  - the `link_state_t` enum (IDLE=0, RX=1, TX=2, GAP=3, WAIT_RESP=4)
  - default constants `USB_IPD_CYCLES` and `USB_RX_TIMEOUT_CYCLES`
- One sub-module, `link_timer`: a CNT_W-bit counter with synchronous clear, enable and a terminal-match input. The arbiter instantiates one timer shared between GAP and WAIT_RESP.

## Test plan
- **TX without response:** with defaults, pulse `tx_req`, then `tx_done` 20 cycles later.
  - `tx_grant` is high for 20 cycles.
  - Then 16 GAP cycles, then IDLE.
  - `timeout` never asserts.
- **TX with `tx_expect_resp`=1, no reply:** after `tx_done`, `timeout` pulses exactly 72 cycles later. `busy` falls on the next cycle.
- **TX with reply:** `rx_line_active` asserts 30 cycles after `tx_done` → RX, and no timeout. `rx_frame_complete` → GAP → IDLE after 16 cycles.
- **Simultaneous events:**
  - `tx_req` and `rx_line_active` together in IDLE → RX, `tx_grant` stays 0. After the GAP, TX is granted.
  - `rx_line_active` on the terminal WAIT_RESP cycle → RX with no `timeout` pulse.
- **Errors:** 300 RX frames ending with `rx_error_flag` → `rx_err_count` saturates at 255. Error and complete in the same cycle count once.
- **Reset mid-TX:** assert `RST` 5 cycles into TX → `drive_en`=0 and `rx_enable`=1 from the next cycle, and `rx_err_count`=0.
